// File: rtl/sgdmac_pkg.sv
// Shared types and AXI constants for the scatter-gather DMA engines.
// Used by sgdmac_write (and its read-side mirror).
package sgdmac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        AW_REQ,
        W_DATA,
        B_WAIT
    } state_e;

    localparam logic [2:0]  AXI_SIZE_4B     = 3'b010;
    localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [15:0] MAX_BURST_BYTES = 16'd64;
    localparam logic [3:0]  MAX_BURST_LEN   = 4'hF;

    function automatic logic [3:0] burst_len(input logic [15:0] remain);
        if (remain >= MAX_BURST_BYTES) begin
            return MAX_BURST_LEN;
        end
        return remain[5:2] - 4'd1;
    endfunction

endpackage

// File: rtl/sgdmac_write.sv
// AXI3 write master: drains the data FIFO into 64 B INCR bursts.
// Define SGDMAC_WRITE_ERR_EN to add the sticky err_o response flag.
module sgdmac_write
    import sgdmac_pkg::*;
#(
    parameter int         FIFO_DEPTH = 64,
    parameter logic [3:0] AXI_ID     = 4'd0,
    localparam int        CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic [3:0]    awid_o,
    output logic [31:0]   awaddr_o,
    output logic [3:0]    awlen_o,
    output logic [2:0]    awsize_o,
    output logic [1:0]    awburst_o,
    output logic          awvalid_o,
    input  logic          awready_i,
    output logic [3:0]    wid_o,
    output logic [31:0]   wdata_o,
    output logic [3:0]    wstrb_o,
    output logic          wlast_o,
    output logic          wvalid_o,
    input  logic          wready_i,
    input  logic [3:0]    bid_i,
    input  logic [1:0]    bresp_i,
    input  logic          bvalid_i,
    output logic          bready_o,
    input  logic          start_i,
    input  logic [47:0]   cmd_i,
    output logic          done_o,
`ifdef SGDMAC_WRITE_ERR_EN
    output logic          err_o,
`endif
    input  logic          fifo_empty_i,
    input  logic [CW-1:0] fifo_cnt_i,
    input  logic [31:0]   fifo_rdata_i,
    output logic          fifo_rden_o
);

    state_e state_q, state_d;

    logic [31:0] addr_q;
    logic [15:0] remain_q;
    logic [3:0]  len_q;
    logic [3:0]  beat_q;
    logic        awvalid_q;

    logic [3:0]  len_c;
    logic [15:0] step_c;
    logic        fifo_ok;
    logic        start_ok;
    logic        aw_hs;
    logic        w_hs;

    assign len_c    = burst_len(remain_q);
    assign step_c   = (remain_q >= MAX_BURST_BYTES)
                    ? MAX_BURST_BYTES : remain_q;
    // Whole burst must sit in the FIFO so W never bubbles.
    assign fifo_ok  = fifo_cnt_i >= (CW'(len_c) + CW'(1));
    assign start_ok = (state_q == IDLE) && start_i;
    assign aw_hs    = awvalid_q && awready_i;
    assign w_hs     = wvalid_o && wready_i;

    assign awid_o    = AXI_ID;
    assign awaddr_o  = addr_q;
    assign awlen_o   = len_c;
    assign awsize_o  = AXI_SIZE_4B;
    assign awburst_o = AXI_BURST_INCR;
    assign awvalid_o = awvalid_q;

    assign wid_o       = AXI_ID;
    assign wdata_o     = fifo_rdata_i;
    assign wstrb_o     = 4'hF;
    assign wvalid_o    = (state_q == W_DATA) && !fifo_empty_i;
    assign wlast_o     = (state_q == W_DATA) && (beat_q == len_q);
    assign fifo_rden_o = w_hs;

    assign bready_o = (state_q == B_WAIT);
    assign done_o   = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = AW_REQ;
            end
            AW_REQ: begin
                if (remain_q == 16'd0) state_d = IDLE;
                else if (aw_hs)        state_d = W_DATA;
            end
            W_DATA: begin
                if (w_hs && wlast_o) state_d = B_WAIT;
            end
            B_WAIT: begin
                if (bvalid_i) begin
                    state_d = (remain_q == 16'd0) ? IDLE : AW_REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            remain_q  <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            awvalid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                addr_q   <= cmd_i[47:16];
                remain_q <= cmd_i[15:0];
            end
            if (aw_hs) begin
                awvalid_q <= 1'b0;
                len_q     <= len_c;
                beat_q    <= '0;
                addr_q    <= addr_q + 32'(MAX_BURST_BYTES);
                remain_q  <= remain_q - step_c;
            end else if ((state_q == AW_REQ) && (remain_q != 16'd0)
                         && fifo_ok) begin
                awvalid_q <= 1'b1;
            end
            if (w_hs) begin
                beat_q <= beat_q + 4'd1;
            end
        end
    end

`ifdef SGDMAC_WRITE_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (start_ok) begin
            err_q <= 1'b0;
        end else if (bvalid_i && bready_o && (bresp_i != AXI_RESP_OKAY)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

    logic unused_in;
    assign unused_in = ^bid_i;
`else
    logic unused_in;
    assign unused_in = ^{bid_i, bresp_i};
`endif

endmodule

// File: tb/tb_sgdmac_write.sv
// Directed self-checking bench for sgdmac_write with an AXI slave
// and FWFT FIFO model.
module tb_sgdmac_write;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awid_o;
    logic [31:0] awaddr_o;
    logic [3:0]  awlen_o;
    logic [2:0]  awsize_o;
    logic [1:0]  awburst_o;
    logic        awvalid_o;
    logic        awready_i;
    logic [3:0]  wid_o;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb_o;
    logic        wlast_o;
    logic        wvalid_o;
    logic        wready_i;
    logic [3:0]  bid_i;
    logic [1:0]  bresp_i;
    logic        bvalid_i;
    logic        bready_o;
    logic        start_i;
    logic [47:0] cmd_i;
    logic        done_o;
`ifdef SGDMAC_WRITE_ERR_EN
    logic        err_o;
`endif
    logic        fifo_empty_i;
    logic [6:0]  fifo_cnt_i;
    logic [31:0] fifo_rdata_i;
    logic        fifo_rden_o;

    int checks = 0;
    int failures = 0;

    sgdmac_write #(.FIFO_DEPTH(64), .AXI_ID(4'd0)) dut (
        .clk(clk), .rst(rst),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o),
        .awsize_o(awsize_o), .awburst_o(awburst_o),
        .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i),
        .bready_o(bready_o), .start_i(start_i), .cmd_i(cmd_i),
        .done_o(done_o),
`ifdef SGDMAC_WRITE_ERR_EN
        .err_o(err_o),
`endif
        .fifo_empty_i(fifo_empty_i), .fifo_cnt_i(fifo_cnt_i),
        .fifo_rdata_i(fifo_rdata_i), .fifo_rden_o(fifo_rden_o)
    );

    always #5 clk = ~clk;

    // slave / FIFO model state
    logic [31:0] fq[$];
    int          fill_left = 0;
    logic [31:0] fill_next = '0;
    bit          rnd_aw = 0, rnd_w = 0, rnd_b = 0;
    int          err_burst = -1;

    logic [31:0] aw_addr_log[$];
    logic [3:0]  aw_len_log[$];
    logic [31:0] beat_log[$];
    int b_count = 0, pop_count = 0, b_idx = 0, pending_b = 0;
    int cyc = 0, aw_hs_cyc = -1, first_beat_cyc = -1, last_beat_cyc = -1;
    int rise_cnt = -1, prev_cnt = 0, cur_beat = 0, cur_len = 0;
    bit w_open = 0, b_hold = 0;
    bit prev_aw_stall = 0, prev_w_stall = 0, prev_awvalid = 0;
    logic [31:0] prev_awaddr, prev_wdata;
    logic [3:0]  prev_awlen;
    logic        prev_wlast;

    always begin
        @(negedge clk);
        if (fill_left > 0) begin
            fq.push_back(fill_next);
            fill_next = fill_next + 1;
            fill_left--;
        end
        fifo_empty_i = (fq.size() == 0);
        fifo_rdata_i = fifo_empty_i ? 32'hDEAD_BEEF : fq[0];
        fifo_cnt_i   = 7'(fq.size());
        awready_i    = rnd_aw ? 1'($urandom % 2) : 1'b1;
        wready_i     = rnd_w ? 1'($urandom % 2) : 1'b1;
        if (b_hold) bvalid_i = 1'b1;
        else bvalid_i = (pending_b > 0) && (rnd_b ? 1'($urandom % 2) : 1'b1);
        bresp_i = (b_idx == err_burst) ? 2'b10 : 2'b00;
        #1;
        cyc++;
        if (!rst) begin
            if (awvalid_o) begin
                checks++;
                if ({awid_o, awsize_o, awburst_o} !== {4'd0, 3'b010, 2'b01}) begin
                    failures++;
                    $display("FAIL aw_fields got=%h want=%h", {awid_o, awsize_o, awburst_o}, {4'd0, 3'b010, 2'b01});
                end
                checks++;
                if (w_open || pending_b != 0) begin
                    failures++;
                    $display("FAIL aw_overlap got=open%0d/pend%0d want=0/0", w_open, pending_b);
                end
            end
            if (prev_aw_stall) begin
                checks++;
                if ({awvalid_o, awaddr_o, awlen_o} !== {1'b1, prev_awaddr, prev_awlen}) begin
                    failures++;
                    $display("FAIL aw_stable got=%h want=%h", {awvalid_o, awaddr_o, awlen_o}, {1'b1, prev_awaddr, prev_awlen});
                end
            end
            if (awvalid_o && !prev_awvalid) begin
                checks++;
                rise_cnt = prev_cnt;
                if (prev_cnt < int'(awlen_o) + 1) begin
                    failures++;
                    $display("FAIL aw_early fifo_cnt=%0d want>=%0d", prev_cnt, int'(awlen_o) + 1);
                end
            end
            if (wvalid_o) begin
                checks++;
                if (!w_open) begin
                    failures++;
                    $display("FAIL w_before_aw got=wvalid want=no wvalid");
                end
                checks++;
                if ({wid_o, wstrb_o, wdata_o} !== {4'd0, 4'hF, fifo_rdata_i}) begin
                    failures++;
                    $display("FAIL w_fields got=%h want=%h", {wid_o, wstrb_o, wdata_o}, {4'd0, 4'hF, fifo_rdata_i});
                end
                checks++;
                if (wlast_o !== 1'(cur_beat == cur_len)) begin
                    failures++;
                    $display("FAIL wlast got=%b want=%b beat=%0d", wlast_o, cur_beat == cur_len, cur_beat);
                end
            end
            if (prev_w_stall) begin
                checks++;
                if ({wvalid_o, wdata_o, wlast_o} !== {1'b1, prev_wdata, prev_wlast}) begin
                    failures++;
                    $display("FAIL w_stable got=%h want=%h", {wvalid_o, wdata_o, wlast_o}, {1'b1, prev_wdata, prev_wlast});
                end
            end
            checks++;
            if (fifo_rden_o !== (wvalid_o & wready_i)) begin
                failures++;
                $display("FAIL rden got=%b want=%b", fifo_rden_o, wvalid_o & wready_i);
            end
            if (awvalid_o && awready_i) begin
                aw_addr_log.push_back(awaddr_o);
                aw_len_log.push_back(awlen_o);
                cur_len = int'(awlen_o);
                cur_beat = 0;
                w_open = 1;
                aw_hs_cyc = cyc;
            end
            if (fifo_rden_o) begin
                pop_count++;
                if (fq.size() > 0) void'(fq.pop_front());
            end
            if (wvalid_o && wready_i) begin
                beat_log.push_back(wdata_o);
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                if (wlast_o) begin
                    w_open = 0;
                    pending_b++;
                end
                cur_beat++;
            end
            if (bvalid_i && bready_o) begin
                b_count++;
                b_idx++;
                if (pending_b > 0) pending_b--;
            end
            b_hold = bvalid_i && !bready_o;
            prev_aw_stall = awvalid_o && !awready_i;
            prev_w_stall  = wvalid_o && !wready_i;
            prev_awvalid  = awvalid_o;
            prev_awaddr   = awaddr_o;
            prev_awlen    = awlen_o;
            prev_wdata    = wdata_o;
            prev_wlast    = wlast_o;
        end else begin
            prev_aw_stall = 0;
            prev_w_stall  = 0;
            prev_awvalid  = 0;
        end
        prev_cnt = int'(fifo_cnt_i);
    end

    task automatic clear_logs();
        aw_addr_log.delete();
        aw_len_log.delete();
        beat_log.delete();
        b_count = 0; pop_count = 0; b_idx = 0;
        aw_hs_cyc = -1; first_beat_cyc = -1; last_beat_cyc = -1;
        rise_cnt = -1;
    endtask

    task automatic preload(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) fq.push_back(base + 32'(i));
    endtask

    task automatic issue(input logic [31:0] a, input logic [15:0] c);
        @(negedge clk);
        start_i = 1'b1;
        cmd_i = {a, c};
        @(negedge clk);
        start_i = 1'b0;
        #2;
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            if (done_o) begin
                ok = 1;
                break;
            end
            @(negedge clk);
            #2;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({awvalid_o, wvalid_o, bready_o, fifo_rden_o, done_o} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=00001", {awvalid_o, wvalid_o, bready_o, fifo_rden_o, done_o});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #2;
        checks++;
        if ({awvalid_o, wvalid_o, done_o} !== 3'b001) begin
            failures++;
            $display("FAIL post_reset got=%b want=001", {awvalid_o, wvalid_o, done_o});
        end
    endtask

    task automatic test_single();
        bit ok;
        clear_logs();
        preload(16, 32'hA000_0000);
        @(negedge clk);
        start_i = 1'b1;
        cmd_i = {32'h0000_1000, 16'd64};
        @(negedge clk);
        start_i = 1'b0;
        #2;
        checks++;
        if ({awvalid_o, done_o} !== 2'b00) begin
            failures++;
            $display("FAIL lat_cycle1 got=%b want=00", {awvalid_o, done_o});
        end
        @(negedge clk);
        #2;
        checks++;
        if (awvalid_o !== 1'b1) begin
            failures++;
            $display("FAIL lat_cycle2 awvalid got=%b want=1", awvalid_o);
        end
        wait_idle(200, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL single_timeout got=busy want=done"); end
        checks++;
        if (aw_addr_log.size() != 1 || aw_addr_log[0] !== 32'h1000 || aw_len_log[0] !== 4'd15) begin
            failures++;
            $display("FAIL single_aw got=n%0d want=1x 1000/15", aw_addr_log.size());
        end
        checks++;
        if (beat_log.size() != 16 || pop_count != 16 || b_count != 1) begin
            failures++;
            $display("FAIL single_counts got=%0d/%0d/%0d want=16/16/1", beat_log.size(), pop_count, b_count);
        end
        for (int i = 0; i < beat_log.size(); i++) begin
            checks++;
            if (beat_log[i] !== 32'hA000_0000 + 32'(i)) begin
                failures++;
                $display("FAIL single_data[%0d] got=%h want=%h", i, beat_log[i], 32'hA000_0000 + 32'(i));
            end
        end
        checks++;
        if (first_beat_cyc - aw_hs_cyc != 1 || last_beat_cyc - first_beat_cyc != 15) begin
            failures++;
            $display("FAIL single_timing got=%0d/%0d want=1/15", first_beat_cyc - aw_hs_cyc, last_beat_cyc - first_beat_cyc);
        end
    endtask

    task automatic test_multi();
        bit ok;
        logic [31:0] ea[4];
        logic [3:0]  el[4];
        ea = '{32'h1000, 32'h1040, 32'h1080, 32'h10C0};
        el = '{4'd15, 4'd15, 4'd15, 4'd1};
        clear_logs();
        preload(50, 32'hB000_0000);
        issue(32'h0000_1000, 16'd200);
        wait_idle(500, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL multi_timeout got=busy want=done"); end
        checks++;
        if (aw_addr_log.size() != 4) begin
            failures++;
            $display("FAIL multi_aw_count got=%0d want=4", aw_addr_log.size());
        end
        for (int i = 0; i < 4 && i < aw_addr_log.size(); i++) begin
            checks++;
            if ({aw_addr_log[i], aw_len_log[i]} !== {ea[i], el[i]}) begin
                failures++;
                $display("FAIL multi_aw[%0d] got=%h/%0d want=%h/%0d", i, aw_addr_log[i], aw_len_log[i], ea[i], el[i]);
            end
        end
        checks++;
        if (beat_log.size() != 50 || pop_count != 50 || b_count != 4) begin
            failures++;
            $display("FAIL multi_counts got=%0d/%0d/%0d want=50/50/4", beat_log.size(), pop_count, b_count);
        end
        checks++;
        if (beat_log.size() == 50 && beat_log[49] !== 32'hB000_0031) begin
            failures++;
            $display("FAIL multi_last_data got=%h want=b0000031", beat_log[49]);
        end
    endtask

    task automatic test_trickle();
        bit ok;
        clear_logs();
        preload(10, 32'hE000_0000);
        fill_next = 32'hE000_000A;
        fill_left = 6;
        issue(32'h0000_6000, 16'd64);
        wait_idle(200, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL trickle_timeout got=busy want=done"); end
        checks++;
        if (rise_cnt != 16) begin
            failures++;
            $display("FAIL trickle_aw_gate got=cnt%0d want=16", rise_cnt);
        end
        checks++;
        if (beat_log.size() != 16 || last_beat_cyc - first_beat_cyc != 15) begin
            failures++;
            $display("FAIL trickle_bubbles got=%0d/%0d want=16/15", beat_log.size(), last_beat_cyc - first_beat_cyc);
        end
        checks++;
        if (beat_log.size() == 16 && beat_log[15] !== 32'hE000_000F) begin
            failures++;
            $display("FAIL trickle_data got=%h want=e000000f", beat_log[15]);
        end
    endtask

    task automatic test_stall();
        bit ok;
        clear_logs();
        preload(32, 32'hC000_0000);
        rnd_aw = 1; rnd_w = 1; rnd_b = 1;
        issue(32'h0000_2000, 16'd128);
        wait_idle(2000, ok);
        rnd_aw = 0; rnd_w = 0; rnd_b = 0;
        checks++;
        if (!ok) begin failures++; $display("FAIL stall_timeout got=busy want=done"); end
        checks++;
        if (aw_addr_log.size() != 2 || aw_addr_log[0] !== 32'h2000 || aw_addr_log[1] !== 32'h2040) begin
            failures++;
            $display("FAIL stall_aw got=n%0d want=2000,2040", aw_addr_log.size());
        end
        checks++;
        if (beat_log.size() != 32 || pop_count != 32 || b_count != 2) begin
            failures++;
            $display("FAIL stall_counts got=%0d/%0d/%0d want=32/32/2", beat_log.size(), pop_count, b_count);
        end
        for (int i = 0; i < beat_log.size(); i++) begin
            checks++;
            if (beat_log[i] !== 32'hC000_0000 + 32'(i)) begin
                failures++;
                $display("FAIL stall_data[%0d] got=%h want=%h", i, beat_log[i], 32'hC000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_zero();
        clear_logs();
        @(negedge clk);
        start_i = 1'b1;
        cmd_i = {32'h0000_7000, 16'd0};
        @(negedge clk);
        start_i = 1'b0;
        #2;
`ifdef SGDMAC_WRITE_ERR_EN
        checks++;
        if (err_o !== 1'b0) begin
            failures++;
            $display("FAIL err_clear got=%b want=0", err_o);
        end
`endif
        checks++;
        if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL zero_busy got=%b want=0", done_o);
        end
        @(negedge clk);
        #2;
        checks++;
        if (done_o !== 1'b1) begin
            failures++;
            $display("FAIL zero_done got=%b want=1", done_o);
        end
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (aw_addr_log.size() != 0 || awvalid_o !== 1'b0) begin
            failures++;
            $display("FAIL zero_no_aw got=n%0d want=0", aw_addr_log.size());
        end
    endtask

`ifdef SGDMAC_WRITE_ERR_EN
    task automatic test_err();
        bit ok;
        clear_logs();
        err_burst = 1;
        preload(48, 32'hF000_0000);
        issue(32'h0000_5000, 16'd192);
        wait_idle(500, ok);
        err_burst = -1;
        checks++;
        if (!ok) begin failures++; $display("FAIL err_timeout got=busy want=done"); end
        checks++;
        if (aw_addr_log.size() != 3 || b_count != 3 || beat_log.size() != 48) begin
            failures++;
            $display("FAIL err_run got=%0d/%0d/%0d want=3/3/48", aw_addr_log.size(), b_count, beat_log.size());
        end
        checks++;
        if (err_o !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got=%b want=1", err_o);
        end
    endtask
`endif

    task automatic test_reset_mid();
        bit ok;
        int n;
        clear_logs();
        preload(16, 32'h9000_0000);
        rnd_w = 1;
        issue(32'h0000_3000, 16'd64);
        n = 0;
        while (beat_log.size() < 2 && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        checks++;
        if (beat_log.size() < 2) begin failures++; $display("FAIL mid_no_beats got=%0d want>=2", beat_log.size()); end
        @(negedge clk);
        start_i = 1'b1;
        cmd_i = {32'h0000_9000, 16'd64};
        @(negedge clk);
        start_i = 1'b0;
        #2;
        checks++;
        if (done_o !== 1'b0 || aw_addr_log.size() != 1) begin
            failures++;
            $display("FAIL mid_start_ignored got=%b/n%0d want=0/1", done_o, aw_addr_log.size());
        end
        @(negedge clk);
        rst = 1'b1;
        #2;
        checks++;
        if ({awvalid_o, wvalid_o, bready_o, fifo_rden_o, done_o} !== 5'b00001) begin
            failures++;
            $display("FAIL mid_reset got=%b want=00001", {awvalid_o, wvalid_o, bready_o, fifo_rden_o, done_o});
        end
        fq.delete();
        pending_b = 0; b_hold = 0; w_open = 0; rnd_w = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        clear_logs();
        preload(4, 32'hD000_0000);
        issue(32'h0000_4000, 16'd16);
        wait_idle(200, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL mid_after_timeout got=busy want=done"); end
        checks++;
        if (aw_addr_log.size() != 1 || aw_addr_log[0] !== 32'h4000 || aw_len_log[0] !== 4'd3) begin
            failures++;
            $display("FAIL mid_after_aw got=n%0d want=1x 4000/3", aw_addr_log.size());
        end
        checks++;
        if (beat_log.size() != 4 || b_count != 1 || beat_log[3] !== 32'hD000_0003) begin
            failures++;
            $display("FAIL mid_after_beats got=%0d/%0d want=4/1", beat_log.size(), b_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        cmd_i = '0;
        bid_i = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_multi();
        test_trickle();
        test_stall();
`ifdef SGDMAC_WRITE_ERR_EN
        test_err();
`endif
        test_zero();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
